// File: rtl/cpu_vector_offload.sv
// CPU-side initiator for the scalar-core to vector-unit coprocessor link.
// Latches one vector op from EX, offers it until acked, and returns scalar results to WB.
module cpu_vector_offload #(
   parameter int MAX_PEND_LSU = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        ex_vec_valid_i,
   input  logic [31:0] ex_vec_inst_i,
   input  logic [31:0] ex_rs1_val_i,
   input  logic [31:0] ex_rs2_val_i,
   input  logic [4:0]  ex_rd_i,
   input  logic        flush_i,
   input  logic        mem_fence_i,
   output logic        stall_o,
   output logic        fence_stall_o,
   output logic        wb_valid_o,
   output logic [4:0]  wb_rd_o,
   output logic [31:0] wb_data_o,
   output logic        protocol_err_o,
   output logic        vector_inst_valid_o,
   output logic [31:0] vector_inst_o,
   output logic [31:0] vector_xrs1_val_o,
   output logic [31:0] vector_xrs2_val_o,
   input  logic        vector_ack_i,
   input  logic        vector_writeback_i,
   input  logic        vector_pend_lsu_i,
   input  logic        vector_lsu_valid_i,
   input  logic        vector_result_valid_i,
   input  logic [31:0] vector_result_i
);

   localparam int CNT_W = $clog2(MAX_PEND_LSU + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RES} state_t;

   state_t             state;
   logic [31:0]        inst_q;
   logic [31:0]        rs1_q;
   logic [31:0]        rs2_q;
   logic [4:0]         rd_q;
   logic [CNT_W-1:0]   cnt;
   logic               err_q;

   logic is_vmem;
   logic lsu_full;
   logic offer;
   logic fire;
   logic inc;
   logic dec;
   logic res_take;

   assign is_vmem  = (inst_q[6:0] == 7'h07) || (inst_q[6:0] == 7'h27);
   assign lsu_full = (cnt == CNT_W'(MAX_PEND_LSU));

   // A vector memory op is held back while the LSU tracker is full; flush kills the offer.
   assign offer    = (state == ISSUE) && !flush_i && !(is_vmem && lsu_full);
   assign fire     = offer && vector_ack_i;
   assign inc      = fire && vector_pend_lsu_i && !lsu_full;
   assign dec      = vector_lsu_valid_i;
   assign res_take = (state == WAIT_RES) && vector_result_valid_i;

   assign vector_inst_valid_o = offer;
   assign vector_inst_o       = inst_q;
   assign vector_xrs1_val_o   = rs1_q;
   assign vector_xrs2_val_o   = rs2_q;
   assign protocol_err_o      = err_q;

   assign wb_valid_o = res_take && (rd_q != 5'd0);
   assign wb_rd_o    = res_take ? rd_q : 5'd0;
   assign wb_data_o  = res_take ? vector_result_i : 32'd0;

   assign fence_stall_o = mem_fence_i && ((cnt != '0) || ((state == ISSUE) && is_vmem));

   always_comb begin
      stall_o = 1'b0;
      case (state)
         IDLE:     stall_o = ex_vec_valid_i;
         // Only a fire without a scalar result lets EX retire from ISSUE.
         ISSUE:    stall_o = !(fire && !vector_writeback_i);
         WAIT_RES: stall_o = !vector_result_valid_i;
         default:  stall_o = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state  <= IDLE;
         inst_q <= '0;
         rs1_q  <= '0;
         rs2_q  <= '0;
         rd_q   <= '0;
         cnt    <= '0;
         err_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (ex_vec_valid_i && !flush_i) begin
                  inst_q <= ex_vec_inst_i;
                  rs1_q  <= ex_rs1_val_i;
                  rs2_q  <= ex_rs2_val_i;
                  rd_q   <= ex_rd_i;
                  state  <= ISSUE;
               end
            end
            ISSUE: begin
               if (flush_i)
                  state <= IDLE;
               else if (fire)
                  state <= vector_writeback_i ? WAIT_RES : IDLE;
            end
            // Flush is ignored here: the VPU already owns the op and will answer.
            WAIT_RES: begin
               if (vector_result_valid_i)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (inc && !dec)
            cnt <= cnt + CNT_W'(1);
         else if (dec && !inc && (cnt != '0))
            cnt <= cnt - CNT_W'(1);

         if ((dec && !inc && (cnt == '0)) || (vector_result_valid_i && (state != WAIT_RES)))
            err_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cpu_vector_offload.sv
// Directed bench for cpu_vector_offload: offer/ack handshake, writeback, LSU gating, fence, flush, errors.
module tb_cpu_vector_offload;

   localparam logic [31:0] VADD    = 32'h02208057;
   localparam logic [31:0] VSETVLI = 32'h0c0072d7;
   localparam logic [31:0] VLE     = 32'h02028007;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        ex_vec_valid_i;
   logic [31:0] ex_vec_inst_i;
   logic [31:0] ex_rs1_val_i;
   logic [31:0] ex_rs2_val_i;
   logic [4:0]  ex_rd_i;
   logic        flush_i;
   logic        mem_fence_i;
   logic        stall_o;
   logic        fence_stall_o;
   logic        wb_valid_o;
   logic [4:0]  wb_rd_o;
   logic [31:0] wb_data_o;
   logic        protocol_err_o;
   logic        vector_inst_valid_o;
   logic [31:0] vector_inst_o;
   logic [31:0] vector_xrs1_val_o;
   logic [31:0] vector_xrs2_val_o;
   logic        vector_ack_i;
   logic        vector_writeback_i;
   logic        vector_pend_lsu_i;
   logic        vector_lsu_valid_i;
   logic        vector_result_valid_i;
   logic [31:0] vector_result_i;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   cpu_vector_offload #(.MAX_PEND_LSU(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .ex_vec_valid_i(ex_vec_valid_i), .ex_vec_inst_i(ex_vec_inst_i),
      .ex_rs1_val_i(ex_rs1_val_i), .ex_rs2_val_i(ex_rs2_val_i), .ex_rd_i(ex_rd_i),
      .flush_i(flush_i), .mem_fence_i(mem_fence_i),
      .stall_o(stall_o), .fence_stall_o(fence_stall_o),
      .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
      .protocol_err_o(protocol_err_o),
      .vector_inst_valid_o(vector_inst_valid_o), .vector_inst_o(vector_inst_o),
      .vector_xrs1_val_o(vector_xrs1_val_o), .vector_xrs2_val_o(vector_xrs2_val_o),
      .vector_ack_i(vector_ack_i), .vector_writeback_i(vector_writeback_i),
      .vector_pend_lsu_i(vector_pend_lsu_i), .vector_lsu_valid_i(vector_lsu_valid_i),
      .vector_result_valid_i(vector_result_valid_i), .vector_result_i(vector_result_i)
   );

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear_inputs;
      ex_vec_valid_i = 0; ex_vec_inst_i = 0; ex_rs1_val_i = 0; ex_rs2_val_i = 0; ex_rd_i = 0;
      flush_i = 0; mem_fence_i = 0; vector_ack_i = 0; vector_writeback_i = 0;
      vector_pend_lsu_i = 0; vector_lsu_valid_i = 0; vector_result_valid_i = 0; vector_result_i = 0;
   endtask

   task automatic do_reset;
      clear_inputs();
      rst_i = 1;
      tick();
      tick();
      rst_i = 0;
   endtask

   // Presents an op in IDLE and returns one cycle later with the DUT in ISSUE.
   task automatic offer_op(input logic [31:0] inst, input logic [4:0] rd);
      ex_vec_valid_i = 1; ex_vec_inst_i = inst; ex_rd_i = rd;
      ex_rs1_val_i = 32'h1000_0000 | inst; ex_rs2_val_i = ~inst;
      tick();
   endtask

   task automatic vle_acked;
      offer_op(VLE, 5'd0);
      vector_ack_i = 1; vector_pend_lsu_i = 1;
      tick();
      vector_ack_i = 0; vector_pend_lsu_i = 0; ex_vec_valid_i = 0;
   endtask

   task automatic test_reset;
      do_reset();
      mem_fence_i = 1;
      #1;
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", stall_o); end
      checks++; if (vector_inst_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", vector_inst_valid_o); end
      checks++; if (vector_inst_o !== 32'd0) begin errors++; $display("FAIL rst_inst got %h exp 0", vector_inst_o); end
      checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL rst_wb got %b exp 0", wb_valid_o); end
      checks++; if (fence_stall_o !== 1'b0) begin errors++; $display("FAIL rst_fence got %b exp 0", fence_stall_o); end
      checks++; if (protocol_err_o !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", protocol_err_o); end
      mem_fence_i = 0;
   endtask

   task automatic test_vadd;
      ex_vec_valid_i = 1; ex_vec_inst_i = VADD; ex_rs1_val_i = 32'h11; ex_rs2_val_i = 32'h22; ex_rd_i = 5'd3;
      #1;
      checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL vadd_idle_stall got %b exp 1", stall_o); end
      checks++; if (vector_inst_valid_o !== 1'b0) begin errors++; $display("FAIL vadd_idle_valid got %b exp 0", vector_inst_valid_o); end
      tick();
      for (int c = 0; c < 3; c++) begin
         vector_ack_i = (c == 2);
         #1;
         checks++; if (vector_inst_valid_o !== 1'b1) begin errors++; $display("FAIL vadd_valid c%0d got %b exp 1", c, vector_inst_valid_o); end
         checks++; if ({vector_inst_o, vector_xrs1_val_o, vector_xrs2_val_o} !== {VADD, 32'h11, 32'h22})
            begin errors++; $display("FAIL vadd_payload c%0d got %h %h %h", c, vector_inst_o, vector_xrs1_val_o, vector_xrs2_val_o); end
         checks++; if (stall_o !== (c != 2)) begin errors++; $display("FAIL vadd_stall c%0d got %b exp %b", c, stall_o, c != 2); end
         tick();
      end
      vector_ack_i = 0; ex_vec_valid_i = 0; mem_fence_i = 1;
      #1;
      checks++; if (vector_inst_valid_o !== 1'b0) begin errors++; $display("FAIL vadd_after_valid got %b exp 0", vector_inst_valid_o); end
      checks++; if (fence_stall_o !== 1'b0) begin errors++; $display("FAIL vadd_cnt_fence got %b exp 0", fence_stall_o); end
      mem_fence_i = 0;
   endtask

   task automatic test_vsetvli(input logic [4:0] rd, input logic [31:0] res, input logic flush_wait);
      offer_op(VSETVLI, rd);
      vector_ack_i = 1; vector_writeback_i = 1;
      #1;
      checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL vset_ack_stall rd%0d got %b exp 1", rd, stall_o); end
      tick();
      vector_ack_i = 0; vector_writeback_i = 0; flush_i = flush_wait;
      #1;
      checks++; if (stall_o !== 1'b1 || wb_valid_o !== 1'b0)
         begin errors++; $display("FAIL vset_wait rd%0d got stall %b wb %b exp 1 0", rd, stall_o, wb_valid_o); end
      tick();
      flush_i = 0; vector_result_valid_i = 1; vector_result_i = res;
      #1;
      checks++; if (wb_valid_o !== (rd != 0)) begin errors++; $display("FAIL vset_wb_valid rd%0d got %b exp %b", rd, wb_valid_o, rd != 0); end
      if (rd != 0) begin
         checks++; if (wb_rd_o !== rd || wb_data_o !== res)
            begin errors++; $display("FAIL vset_wb_data got rd %0d data %h exp %0d %h", wb_rd_o, wb_data_o, rd, res); end
      end
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL vset_res_stall got %b exp 0", stall_o); end
      tick();
      vector_result_valid_i = 0; ex_vec_valid_i = 0;
      #1;
      checks++; if (wb_valid_o !== 1'b0 || stall_o !== 1'b0)
         begin errors++; $display("FAIL vset_after got wb %b stall %b exp 0 0", wb_valid_o, stall_o); end
   endtask

   task automatic test_lsu_limit;
      repeat (4) vle_acked();
      offer_op(VLE, 5'd0);
      vector_ack_i = 1; vector_pend_lsu_i = 1;
      #1;
      checks++; if (vector_inst_valid_o !== 1'b0 || stall_o !== 1'b1)
         begin errors++; $display("FAIL lsu_full got valid %b stall %b exp 0 1", vector_inst_valid_o, stall_o); end
      tick();
      mem_fence_i = 1;
      #1;
      checks++; if (fence_stall_o !== 1'b1) begin errors++; $display("FAIL lsu_full_fence got %b exp 1", fence_stall_o); end
      tick();
      vector_lsu_valid_i = 1;
      #1;
      checks++; if (vector_inst_valid_o !== 1'b0) begin errors++; $display("FAIL lsu_dec_cycle_valid got %b exp 0", vector_inst_valid_o); end
      tick();
      vector_lsu_valid_i = 0;
      #1;
      checks++; if (vector_inst_valid_o !== 1'b1 || stall_o !== 1'b0)
         begin errors++; $display("FAIL lsu_release got valid %b stall %b exp 1 0", vector_inst_valid_o, stall_o); end
      tick();
      vector_ack_i = 0; vector_pend_lsu_i = 0; ex_vec_valid_i = 0;
      repeat (4) begin vector_lsu_valid_i = 1; tick(); end
      vector_lsu_valid_i = 0;
      #1;
      checks++; if (fence_stall_o !== 1'b0) begin errors++; $display("FAIL lsu_drained_fence got %b exp 0", fence_stall_o); end
      checks++; if (protocol_err_o !== 1'b0) begin errors++; $display("FAIL lsu_drained_err got %b exp 0", protocol_err_o); end
      mem_fence_i = 0;
   endtask

   task automatic test_fence;
      mem_fence_i = 1;
      offer_op(VLE, 5'd0);
      #1;
      checks++; if (fence_stall_o !== 1'b1) begin errors++; $display("FAIL fence_issue_vmem got %b exp 1", fence_stall_o); end
      vector_ack_i = 1; vector_pend_lsu_i = 1;
      tick();
      vector_ack_i = 0; vector_pend_lsu_i = 0; ex_vec_valid_i = 0;
      vle_acked();
      offer_op(VLE, 5'd0);
      vector_ack_i = 1; vector_pend_lsu_i = 1; vector_lsu_valid_i = 1;
      tick();
      vector_ack_i = 0; vector_pend_lsu_i = 0; vector_lsu_valid_i = 0; ex_vec_valid_i = 0;
      #1;
      checks++; if (fence_stall_o !== 1'b1) begin errors++; $display("FAIL fence_cnt2 got %b exp 1", fence_stall_o); end
      vector_lsu_valid_i = 1;
      tick();
      vector_lsu_valid_i = 0;
      #1;
      checks++; if (fence_stall_o !== 1'b1) begin errors++; $display("FAIL fence_cnt1 got %b exp 1", fence_stall_o); end
      vector_lsu_valid_i = 1;
      tick();
      vector_lsu_valid_i = 0;
      #1;
      checks++; if (fence_stall_o !== 1'b0) begin errors++; $display("FAIL fence_cnt0 got %b exp 0", fence_stall_o); end
      mem_fence_i = 0;
   endtask

   task automatic test_flush;
      offer_op(VLE, 5'd4);
      flush_i = 1; vector_ack_i = 1; vector_pend_lsu_i = 1;
      #1;
      checks++; if (vector_inst_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", vector_inst_valid_o); end
      tick();
      clear_inputs();
      mem_fence_i = 1;
      #1;
      checks++; if (vector_inst_valid_o !== 1'b0 || stall_o !== 1'b0 || wb_valid_o !== 1'b0)
         begin errors++; $display("FAIL flush_idle got valid %b stall %b wb %b exp 0 0 0", vector_inst_valid_o, stall_o, wb_valid_o); end
      checks++; if (fence_stall_o !== 1'b0) begin errors++; $display("FAIL flush_cnt_fence got %b exp 0", fence_stall_o); end
      mem_fence_i = 0;
      test_vsetvli(5'd7, 32'hCAFE_0007, 1'b1);
      checks++; if (protocol_err_o !== 1'b0) begin errors++; $display("FAIL flush_err got %b exp 0", protocol_err_o); end
   endtask

   task automatic test_protocol_err;
      do_reset();
      vector_lsu_valid_i = 1;
      tick();
      vector_lsu_valid_i = 0;
      repeat (3) tick();
      checks++; if (protocol_err_o !== 1'b1) begin errors++; $display("FAIL err_lsu_sticky got %b exp 1", protocol_err_o); end
      do_reset();
      #1;
      checks++; if (protocol_err_o !== 1'b0) begin errors++; $display("FAIL err_cleared got %b exp 0", protocol_err_o); end
      vector_result_valid_i = 1; vector_result_i = 32'h55;
      #1;
      checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL err_res_wb got %b exp 0", wb_valid_o); end
      tick();
      vector_result_valid_i = 0;
      #1;
      checks++; if (protocol_err_o !== 1'b1) begin errors++; $display("FAIL err_res got %b exp 1", protocol_err_o); end
      do_reset();
      vle_acked();
      offer_op(VLE, 5'd0);
      rst_i = 1; ex_vec_valid_i = 0;
      tick();
      rst_i = 0; mem_fence_i = 1;
      #1;
      checks++; if (vector_inst_valid_o !== 1'b0 || stall_o !== 1'b0 || vector_inst_o !== 32'd0 || vector_xrs1_val_o !== 32'd0)
         begin errors++; $display("FAIL midrst_offer got valid %b stall %b inst %h rs1 %h exp 0", vector_inst_valid_o, stall_o, vector_inst_o, vector_xrs1_val_o); end
      checks++; if (fence_stall_o !== 1'b0 || protocol_err_o !== 1'b0 || wb_valid_o !== 1'b0)
         begin errors++; $display("FAIL midrst_misc got fence %b err %b wb %b exp 0", fence_stall_o, protocol_err_o, wb_valid_o); end
      mem_fence_i = 0;
   endtask

   initial begin
      test_reset();
      test_vadd();
      test_vsetvli(5'd5, 32'h10, 1'b0);
      test_vsetvli(5'd0, 32'h10, 1'b0);
      test_lsu_limit();
      test_fence();
      test_flush();
      test_protocol_err();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
